// File: rtl/inv_sub_byte_if.sv
// Valid/ready bus for the inverse SubBytes engine: one state in, one state out.
interface inv_sub_byte_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/inv_sub_byte.sv
// AES inverse SubBytes: LANES shared inverse S-boxes sweep the 16-byte state
// from byte 0 upward, then the result is held until downstream accepts it.
module inv_sub_byte #(
  parameter int DATA_WIDTH     = 128,
  parameter int LANES          = 4,
  parameter int SELECT_SUBBYTE = 1
) (
  input  logic         clk,
  input  logic         rst,
  inv_sub_byte_if.slave io_bus,
  output logic         o_busy
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int N         = NUM_BYTES / LANES;
  localparam int CNT_W     = $clog2(N + 1);
  localparam int LW        = 8 * LANES;

  if (DATA_WIDTH != 128 ||
      (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16)) begin : g_param_err
    $error("inv_sub_byte: DATA_WIDTH must be 128 and LANES one of 1,2,4,8,16");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_work;
  logic [DATA_WIDTH-1:0] w_work_nxt;
  logic [LW-1:0]         w_lane_in;
  logic [LW-1:0]         w_lane_out;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox_gf(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [7:0] inv_sbox_lut(input logic [7:0] x);
    logic [7:0] y;
    case (x)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
      8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
      8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
      8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
      8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
      8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
      8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
      8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
      8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
      8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
      8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
      8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
      8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
      8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
      8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
      8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
      default: y = 8'h00;
    endcase
    return y;
  endfunction

  // Window of LANES bytes selected by the beat counter.
  assign w_lane_in = LW'(r_work >> (int'(r_cnt) * LW));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (SELECT_SUBBYTE != 0) begin : g_lut
      assign w_lane_out[8*l +: 8] = inv_sbox_lut(w_lane_in[8*l +: 8]);
    end else begin : g_gf
      assign w_lane_out[8*l +: 8] = inv_sbox_gf(w_lane_in[8*l +: 8]);
    end
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (b / LANES == int'(r_cnt)) w_work_nxt[8*b +: 8] = w_lane_out[8*(b % LANES) +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.in_valid) w_next = S_RUN;
      S_RUN:   if (r_cnt == CNT_W'(N - 1)) w_next = S_HOLD;
      S_HOLD:  if (io_bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    io_bus.in_ready  = (r_state == S_IDLE);
    io_bus.out_valid = (r_state == S_HOLD);
    o_busy           = (r_state != S_IDLE);
  end

  assign io_bus.out_data = r_work;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_work <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (io_bus.in_valid) begin
          r_work <= io_bus.in_data;
          r_cnt  <= '0;
        end
        S_RUN: begin
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sub_byte.sv
// Scoreboard bench: three engines (LUT/LANES=4, GF/LANES=1, GF/LANES=16) share clock and reset.
module tb_inv_sub_byte;
  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic                drv_valid [3];
  logic [127:0]        drv_data  [3];
  logic                drv_ready [3];
  logic [2:0]          st_in_ready;
  logic [2:0]          st_out_valid;
  logic [2:0]          st_busy;
  logic [127:0]        st_out_data [3];
  logic [127:0]        exp_q [3][$];
  int                  hs_q  [3][$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LN  = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    localparam int SEL = (g == 0) ? 1 : 0;
    localparam int LAT = 16 / LN;
    logic prev_ov;

    inv_sub_byte_if #(.DATA_WIDTH(128)) u_if ();

    inv_sub_byte #(.DATA_WIDTH(128), .LANES(LN), .SELECT_SUBBYTE(SEL)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (u_if.slave),
      .o_busy (st_busy[g])
    );

    assign u_if.in_valid   = drv_valid[g];
    assign u_if.in_data    = drv_data[g];
    assign u_if.out_ready  = drv_ready[g];
    assign st_in_ready[g]  = u_if.in_ready;
    assign st_out_valid[g] = u_if.out_valid;
    assign st_out_data[g]  = u_if.out_data;

    always @(negedge clk) begin
      if (rst) begin
        prev_ov <= 1'b0;
      end else begin
        prev_ov <= u_if.out_valid;
        if (u_if.out_valid && !prev_ov) begin
          chk($sformatf("d%0d_lat_pending", g), 128'(hs_q[g].size() > 0), 128'd1);
          if (hs_q[g].size() > 0) chk($sformatf("d%0d_latency", g), 128'(cyc - hs_q[g].pop_front()), 128'(LAT));
        end
        if (u_if.out_valid && u_if.out_ready) begin
          chk($sformatf("d%0d_out_expected", g), 128'(exp_q[g].size() > 0), 128'd1);
          if (exp_q[g].size() > 0) chk($sformatf("d%0d_out_data", g), u_if.out_data, exp_q[g].pop_front());
        end
      end
    end
  end

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box reference: brute-force inverse, then the forward affine map.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) if (m_mul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] fwd_block(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_sbox(x[8*i +: 8]);
    return r;
  endfunction

  task automatic send(input logic [2:0] mask, input logic [127:0] d, input logic [127:0] e,
                      output int hs);
    int t;
    t = 0;
    while (((st_in_ready & mask) != mask) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_wait", 128'(st_in_ready & mask), 128'(mask));
    hs = cyc + 1;
    for (int g = 0; g < 3; g++) if (mask[g]) begin
      drv_valid[g] = 1'b1;
      drv_data[g]  = d;
      exp_q[g].push_back(e);
      hs_q[g].push_back(hs);
    end
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) if (mask[g]) drv_valid[g] = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 128'd0);
  endtask

  task automatic wait_out_valid0();
    int t;
    t = 0;
    while (!st_out_valid[0] && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("out_valid_wait", 128'(st_out_valid[0]), 128'd1);
  endtask

  initial begin
    int hs;
    int hs_prev;
    logic [127:0] a_exp;
    logic [127:0] x;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      drv_valid[g] = 1'b0;
      drv_data[g]  = '0;
      drv_ready[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("d%0d_rst_in_ready", g), 128'(st_in_ready[g]), 128'd1);
      chk($sformatf("d%0d_rst_out_valid", g), 128'(st_out_valid[g]), 128'd0);
      chk($sformatf("d%0d_rst_busy", g), 128'(st_busy[g]), 128'd0);
      chk($sformatf("d%0d_rst_work", g), st_out_data[g], 128'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // All-0x63 block on the LANES=4 engine, then in_ready after the out handshake.
    send(3'b001, {16{8'h63}}, 128'h0, hs);
    chk("busy_run", 128'(st_busy[0]), 128'd1);
    wait_out_valid0();
    @(posedge clk); #1;
    chk("in_ready_after_out", 128'(st_in_ready[0]), 128'd1);
    chk("busy_after_out", 128'(st_busy[0]), 128'd0);

    // Spot values on all three engines.
    send(3'b111, {{12{8'h63}}, 8'h00, 8'hED, 8'h16, 8'h7C},
         {{12{8'h00}}, 8'h52, 8'h53, 8'hFF, 8'h01}, hs);
    drain();

    // Round trip over x = 0..255 on every engine.
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) x[8*i +: 8] = 8'(16 * b + i);
      send(3'b111, fwd_block(x), x, hs);
    end
    drain();

    // Back-pressure: hold for 10 cycles while in_valid toggles with fresh data.
    drv_ready[0] = 1'b0;
    x = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    a_exp = x;
    send(3'b001, fwd_block(x), a_exp, hs);
    wait_out_valid0();
    for (int i = 0; i < 10; i++) begin
      drv_valid[0] = (i % 2 == 0);
      drv_data[0]  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_out_data", st_out_data[0], a_exp);
      chk("bp_in_ready", 128'(st_in_ready[0]), 128'd0);
      chk("bp_out_valid", 128'(st_out_valid[0]), 128'd1);
    end
    x = {$urandom, $urandom, $urandom, $urandom};
    drv_ready[0] = 1'b1;
    drv_valid[0] = 1'b1;
    drv_data[0]  = fwd_block(x);
    exp_q[0].push_back(x);
    hs_q[0].push_back(cyc + 2);
    @(posedge clk); #1;
    chk("bp_release_in_ready", 128'(st_in_ready[0]), 128'd1);
    @(posedge clk); #1;
    drv_valid[0] = 1'b0;
    chk("bp_captured_busy", 128'(st_busy[0]), 128'd1);
    drain();

    // Asynchronous reset in the middle of RUN (cnt = 2).
    send(3'b001, {16{8'h52}}, {16{8'h48}}, hs);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 128'(st_busy[0]), 128'd0);
    chk("arst_out_valid", 128'(st_out_valid[0]), 128'd0);
    chk("arst_work", st_out_data[0], 128'd0);
    chk("arst_in_ready", 128'(st_in_ready[0]), 128'd1);
    for (int g = 0; g < 3; g++) begin
      exp_q[g].delete();
      hs_q[g].delete();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    x = 128'hdead_beef_0bad_f00d_1357_9bdf_2468_ace0;
    send(3'b001, fwd_block(x), x, hs);
    drain();

    // Back-to-back blocks with out_ready held high.
    hs_prev = 0;
    for (int k = 0; k < 5; k++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(3'b001, fwd_block(x), x, hs);
      if (k > 0) chk("b2b_spacing", 128'(hs - hs_prev), 128'd6);
      hs_prev = hs;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
